// File: rtl/cpu_run_monitor.sv
// Run controller and instruction-trace buffer for the single-cycle MIPS core.
// Gates the core with halt, records the last TRACE_DEPTH {pc, instr} pairs, then streams them oldest first.
module cpu_run_monitor #(
  parameter int DATA_W      = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int NUM_BP      = 2,
  parameter int CYC_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CYC_W-1:0]         cycle_limit,
  input  logic [NUM_BP*DATA_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instr,
  output logic                     halt,
  output logic                     done,
  output logic [1:0]               halt_cause,
  output logic [CYC_W-1:0]         cycle_cnt,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [DATA_W-1:0]        dump_pc,
  output logic [DATA_W-1:0]        dump_instr,
  output logic                     dump_last
);

  localparam int PTR_W  = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TRACE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_ABORT = 2'd3;

  logic [1:0]        state;
  logic              start_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] remain;

  logic [DATA_W-1:0] trace_pc    [TRACE_DEPTH];
  logic [DATA_W-1:0] trace_instr [TRACE_DEPTH];

  logic              bp_hit;
  logic              limit_hit;
  logic              stop;
  logic [1:0]        stop_cause;
  logic [CYC_W-1:0]  cnt_inc;
  logic [CYC_W-1:0]  cnt_nxt;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [PTR_W-1:0]  rd_start;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    bp_hit = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bp_en[k] && (pc == bp_addr[k*DATA_W +: DATA_W])) bp_hit = 1'b1;
    end
  end

  assign cnt_inc   = cycle_cnt + CYC_W'(1);
  assign cnt_nxt   = (&cycle_cnt) ? cycle_cnt : cnt_inc;
  assign limit_hit = (cycle_limit != '0) && (cnt_inc == cycle_limit);
  assign stop      = abort || bp_hit || limit_hit;

  always_comb begin
    stop_cause = CAUSE_NONE;
    if (abort)          stop_cause = CAUSE_ABORT;
    else if (bp_hit)    stop_cause = CAUSE_BP;
    else if (limit_hit) stop_cause = CAUSE_LIMIT;
  end

  // Pointer and fill values including the capture happening on this edge,
  // so a stop on this cycle dumps its own entry too.
  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign fill_nxt   = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
  assign rd_start   = wr_ptr_nxt - fill_nxt[PTR_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      remain     <= '0;
    end else begin
      // start is registered once, which puts the first capture two edges after it is seen.
      start_q <= start && ((state == S_IDLE) || (state == S_DONE));

      case (state)
        S_IDLE, S_DONE: begin
          if (start_q) begin
            state      <= S_RUN;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
          end
        end

        S_RUN: begin
          wr_ptr    <= wr_ptr_nxt;
          fill      <= fill_nxt;
          cycle_cnt <= cnt_nxt;
          if (stop) begin
            state      <= S_DUMP;
            halt_cause <= stop_cause;
            rd_ptr     <= rd_start;
            remain     <= fill_nxt;
          end
        end

        S_DUMP: begin
          if (dump_ready) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            remain <= remain - FILL_W'(1);
            if (remain == FILL_W'(1)) state <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the trace RAM has no reset; its contents are only read after being written in a run.
  always_ff @(posedge clk) begin
    if (state == S_RUN) begin
      trace_pc[wr_ptr]    <= pc;
      trace_instr[wr_ptr] <= instr;
    end
  end

  assign halt       = (state != S_RUN);
  assign done       = (state == S_DONE);
  assign dump_valid = (state == S_DUMP);
  assign dump_last  = dump_valid && (remain == FILL_W'(1));
  assign dump_pc    = dump_valid ? trace_pc[rd_ptr]    : '0;
  assign dump_instr = dump_valid ? trace_instr[rd_ptr] : '0;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: a stepping core model feeds pc/instr, a scoreboard
// queue holds expected dump words and run results, a monitor process compares them.
module tb_cpu_run_monitor;

  localparam int DATA_W      = 32;
  localparam int TRACE_DEPTH = 16;
  localparam int NUM_BP      = 2;
  localparam int CYC_W       = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     abort;
  logic [CYC_W-1:0]         cycle_limit;
  logic [NUM_BP*DATA_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic [DATA_W-1:0]        pc;
  logic [DATA_W-1:0]        instr;
  logic                     halt;
  logic                     done;
  logic [1:0]               halt_cause;
  logic [CYC_W-1:0]         cycle_cnt;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [DATA_W-1:0]        dump_pc;
  logic [DATA_W-1:0]        dump_instr;
  logic                     dump_last;

  logic                     pc_load;
  logic [DATA_W-1:0]        pc_base;
  int                       ready_mode;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        last;
  } dump_t;

  typedef struct {
    logic [1:0]  cause;
    logic [15:0] cnt;
  } res_t;

  dump_t dump_q[$];
  res_t  res_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  cpu_run_monitor #(
    .DATA_W(DATA_W), .TRACE_DEPTH(TRACE_DEPTH), .NUM_BP(NUM_BP), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cycle_limit(cycle_limit), .bp_addr(bp_addr), .bp_en(bp_en),
    .pc(pc), .instr(instr), .halt(halt), .done(done),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_pc(dump_pc), .dump_instr(dump_instr), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {p[15:0], ~p[15:0]};
  endfunction

  // Core model: PC advances by one word every unhalted cycle.
  always @(posedge clk) begin
    if (pc_load)    pc <= pc_base;
    else if (!halt) pc <= pc + 32'd4;
  end
  assign instr = instr_of(pc);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_trace(input logic [31:0] first_pc, input int count, input bit mark_last);
    for (int i = 0; i < count; i++) begin
      dump_q.push_back('{first_pc + 32'(4 * i), instr_of(first_pc + 32'(4 * i)),
                         mark_last && (i == count - 1)});
    end
  endtask

  task automatic push_result(input logic [1:0] cause, input logic [15:0] cnt);
    res_q.push_back('{cause, cnt});
  endtask

  // Ready pattern: 0 = always high, 1 = toggle every cycle, 2 = low.
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       dump_ready = ~dump_ready;
        2:       dump_ready = 1'b0;
        default: dump_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every presented dump word and each run result at DONE entry.
  initial begin
    logic  done_prev;
    dump_t e;
    res_t  r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && dump_valid) begin
        if (dump_q.size() == 0) begin
          fail_now($sformatf("dump word pc=0x%0h with empty scoreboard", dump_pc));
        end else begin
          e = dump_q[0];
          check($sformatf("dump_pc[%0d]", n_words), dump_pc, e.pc);
          check($sformatf("dump_instr[%0d]", n_words), dump_instr, e.instr);
          check($sformatf("dump_last[%0d]", n_words), dump_last, e.last);
          if (dump_ready) begin
            void'(dump_q.pop_front());
            n_words++;
          end
        end
      end
      if (!rst && done && !done_prev) begin
        if (res_q.size() == 0) begin
          fail_now("done entered with no expected result");
        end else begin
          r = res_q.pop_front();
          check("halt_cause", halt_cause, r.cause);
          check("cycle_cnt", cycle_cnt, r.cnt);
        end
      end
      done_prev = done;
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pc_load = 1'b1;
    pc_base = 32'h3000;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    pc_load = 1'b0;
  endtask

  // Pulses start together with the core PC load; returns at a negedge in the first RUN cycle.
  task automatic start_run(input string tag, input logic [31:0] base);
    @(posedge clk);
    #1;
    pc_base = base;
    pc_load = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pc_load = 1'b0;
    @(negedge clk);
    check({tag, "_halt_before_run"}, halt, 1'b1);
    @(negedge clk);
    check({tag, "_halt_in_run"}, halt, 1'b0);
    check({tag, "_cnt_cleared"}, cycle_cnt, 16'h0);
  endtask

  // Waits for the stop, checks the last captured PC, then counts cycles until DONE.
  task automatic wait_stop(input string tag, input logic [31:0] exp_pc, input int exp_words);
    logic [31:0] last_pc;
    int          n;
    bit          ok;
    last_pc = pc;
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (halt) begin
        ok = 1'b1;
        break;
      end
      last_pc = pc;
    end
    if (!ok) begin
      fail_now({tag, "_stop_timeout"});
      return;
    end
    check({tag, "_dump_valid_at_stop"}, dump_valid, 1'b1);
    check({tag, "_last_captured_pc"}, last_pc, exp_pc);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({tag, "_done_timeout"});
    else if (exp_words >= 0) check({tag, "_dump_cycles"}, n, exp_words);
  endtask

  initial begin
    bit   ok;
    int   w0;
    logic [31:0] ab_pc;

    #20000000;
    fail_now("global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          w0;
    logic [31:0] ab_pc;

    ready_mode  = 0;
    cycle_limit = '0;
    bp_addr     = {32'h3008, 32'h3010};
    bp_en       = '0;
    do_reset();

    @(negedge clk);
    check("rst_halt", halt, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_cause", halt_cause, 2'd0);
    check("rst_cnt", cycle_cnt, 16'h0);
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_dump_last", dump_last, 1'b0);
    check("rst_dump_pc", dump_pc, 32'h0);
    check("rst_dump_instr", dump_instr, 32'h0);

    // abort while idle has no effect
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("idle_abort_halt", halt, 1'b1);
    check("idle_abort_cause", halt_cause, 2'd0);

    // limit of 40 wraps the 16-entry trace
    cycle_limit = 16'd40;
    push_trace(32'h3060, 16, 1'b1);
    push_result(2'd1, 16'd40);
    start_run("limit", 32'h3000);
    wait_stop("limit", 32'h309C, 16);

    // breakpoint in slot 0; slot 1 (0x3008) disabled
    cycle_limit = 16'd0;
    bp_en       = 2'b01;
    push_trace(32'h3000, 5, 1'b1);
    push_result(2'd2, 16'd5);
    start_run("bp", 32'h3000);
    wait_stop("bp", 32'h3010, 5);

    // breakpoint and limit coincide
    cycle_limit = 16'd3;
    bp_en       = 2'b10;
    push_trace(32'h3000, 3, 1'b1);
    push_result(2'd2, 16'd3);
    start_run("bp_vs_limit", 32'h3000);
    wait_stop("bp_vs_limit", 32'h3008, 3);

    // abort coincides with breakpoint and limit
    push_trace(32'h3000, 3, 1'b1);
    push_result(2'd3, 16'd3);
    start_run("abort_prio", 32'h3000);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pc == 32'h3008) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("abort_prio_pc_timeout");
    abort = 1'b1;
    wait_stop("abort_prio", 32'h3008, 3);
    abort = 1'b0;

    // backpressure: ready toggles during the dump
    cycle_limit = 16'd0;
    bp_addr     = {32'h3008, 32'h3020};
    bp_en       = 2'b01;
    ready_mode  = 1;
    push_trace(32'h3000, 9, 1'b1);
    push_result(2'd2, 16'd9);
    start_run("backpressure", 32'h3000);
    wait_stop("backpressure", 32'h3020, -1);
    ready_mode  = 0;

    // unlimited run from DONE saturates the cycle counter, ended by abort
    bp_en = 2'b00;
    start_run("unlimited", 32'h3000);
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (cycle_cnt == 16'hFFFF) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("unlimited_saturation_timeout");
    repeat (5) @(negedge clk);
    check("unlimited_cnt_saturated", cycle_cnt, 16'hFFFF);
    check("unlimited_still_running", halt, 1'b0);
    ab_pc = pc;
    push_trace(ab_pc - 32'd60, 16, 1'b1);
    push_result(2'd3, 16'hFFFF);
    abort = 1'b1;
    wait_stop("unlimited", ab_pc, 16);
    abort = 1'b0;

    // reset after 3 of 16 dump words
    cycle_limit = 16'd40;
    push_trace(32'h3060, 3, 1'b0);
    start_run("rst_dump", 32'h3000);
    w0 = n_words;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (n_words == w0 + 3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("rst_dump_words_timeout");
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_dump_valid_after", dump_valid, 1'b0);
    check("rst_dump_halt_after", halt, 1'b1);
    check("rst_dump_cause_after", halt_cause, 2'd0);
    check("rst_dump_done_after", done, 1'b0);
    check("rst_dump_cnt_after", cycle_cnt, 16'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dump_stays_idle", dump_valid, 1'b0);

    check("dump_queue_drained", dump_q.size(), 0);
    check("result_queue_drained", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
